// File: rtl/ex_pkg.sv
// Shared op codes, FSM state type and default latencies for the MIPS execute stage.
package ex_pkg;

  localparam int unsigned DATA_W          = 32;
  localparam int unsigned DEF_MULT_CYCLES = 5;
  localparam int unsigned DEF_DIV_CYCLES  = 10;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10,
    ALU_SLLV = 4'd11,
    ALU_SRLV = 4'd12,
    ALU_SRAV = 4'd13,
    ALU_LUI  = 4'd14
  } alu_op_e;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

endpackage

// File: rtl/ex_stage_md_unit.sv
// Multi-cycle multiply/divide unit: computes at start, holds the result pending,
// and commits it to HI/LO when the busy countdown expires.
module md_unit
  import ex_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid,
  input  logic [3:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        md_busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  md_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       hi_q, hi_d, lo_q, lo_d;
  logic [31:0]       pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic              pend_wr_q, pend_wr_d;

  logic              is_mul, is_div, is_signed, start, busy;
  logic [63:0]       mul_a, mul_b, product;
  logic              a_neg, b_neg;
  logic [31:0]       abs_a, abs_b, quo_u, rem_u, quo, rem;

  assign is_mul    = (md_op == MD_MULT) || (md_op == MD_MULTU);
  assign is_div    = (md_op == MD_DIV)  || (md_op == MD_DIVU);
  assign is_signed = (md_op == MD_MULT) || (md_op == MD_DIV);
  assign start     = valid && (is_mul || is_div);
  assign busy      = (state_q == ST_BUSY);
  // While reset is high only a fresh start request is reported.
  assign md_busy   = start || (busy && !reset);
  assign hi        = hi_q;
  assign lo        = lo_q;

  // Datapath: 64-bit product and sign-magnitude division truncated toward zero.
  always_comb begin
    mul_a   = is_signed ? {{32{src_a[31]}}, src_a} : {32'h0, src_a};
    mul_b   = is_signed ? {{32{src_b[31]}}, src_b} : {32'h0, src_b};
    product = mul_a * mul_b;
    a_neg   = is_signed && src_a[31];
    b_neg   = is_signed && src_b[31];
    abs_a   = a_neg ? (~src_a + 32'd1) : src_a;
    abs_b   = b_neg ? (~src_b + 32'd1) : src_b;
    quo_u   = 32'h0;
    rem_u   = 32'h0;
    if (abs_b != 32'h0) begin
      quo_u = abs_a / abs_b;
      rem_u = abs_a % abs_b;
    end
    quo = (a_neg ^ b_neg) ? (~quo_u + 32'd1) : quo_u;
    rem = a_neg ? (~rem_u + 32'd1) : rem_u;
  end

  // Next-state logic: start loads pending result, countdown commits it.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_BUSY;
          cnt_d   = is_mul ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
          if (is_mul) begin
            pend_hi_d = product[63:32];
            pend_lo_d = product[31:0];
            pend_wr_d = 1'b1;
          end else begin
            pend_hi_d = rem;
            pend_lo_d = quo;
            pend_wr_d = (src_b != 32'h0);
          end
        end else if (valid && (md_op == MD_MTHI)) begin
          hi_d = src_a;
        end else if (valid && (md_op == MD_MTLO)) begin
          lo_d = src_a;
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          if (pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      hi_q      <= 32'h0;
      lo_q      <= 32'h0;
      pend_hi_q <= 32'h0;
      pend_lo_q <= 32'h0;
      pend_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
    end
  end

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: combinational ALU, HI/LO read mux and the mul/div unit.
module ex_stage
  import ex_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_Ex,
  input  logic [31:0] src_a_Ex,
  input  logic [31:0] src_b_Ex,
  input  logic [4:0]  shamt_Ex,
  input  logic [3:0]  alu_op_Ex,
  input  logic [3:0]  md_op_Ex,
  output logic [31:0] aluAns_Ex,
  output logic        md_busy,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  logic [31:0] alu_res;
  logic [4:0]  var_sh;

  assign var_sh = src_a_Ex[4:0];

  always_comb begin
    alu_res = 32'h0;
    case (alu_op_Ex)
      ALU_ADD:  alu_res = src_a_Ex + src_b_Ex;
      ALU_SUB:  alu_res = src_a_Ex - src_b_Ex;
      ALU_AND:  alu_res = src_a_Ex & src_b_Ex;
      ALU_OR:   alu_res = src_a_Ex | src_b_Ex;
      ALU_XOR:  alu_res = src_a_Ex ^ src_b_Ex;
      ALU_NOR:  alu_res = ~(src_a_Ex | src_b_Ex);
      ALU_SLT:  alu_res = {31'h0, $signed(src_a_Ex) < $signed(src_b_Ex)};
      ALU_SLTU: alu_res = {31'h0, src_a_Ex < src_b_Ex};
      ALU_SLL:  alu_res = src_b_Ex << shamt_Ex;
      ALU_SRL:  alu_res = src_b_Ex >> shamt_Ex;
      ALU_SRA:  alu_res = 32'($signed(src_b_Ex) >>> shamt_Ex);
      ALU_SLLV: alu_res = src_b_Ex << var_sh;
      ALU_SRLV: alu_res = src_b_Ex >> var_sh;
      ALU_SRAV: alu_res = 32'($signed(src_b_Ex) >>> var_sh);
      ALU_LUI:  alu_res = {src_b_Ex[15:0], 16'h0};
      default:  alu_res = 32'h0;
    endcase
  end

  // MFHI/MFLO take the HI/LO registers in place of the ALU result.
  always_comb begin
    aluAns_Ex = alu_res;
    if (md_op_Ex == MD_MFHI) aluAns_Ex = hi_out;
    else if (md_op_Ex == MD_MFLO) aluAns_Ex = lo_out;
  end

  md_unit #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md (
    .clk     (clk),
    .reset   (reset),
    .valid   (valid_Ex),
    .md_op   (md_op_Ex),
    .src_a   (src_a_Ex),
    .src_b   (src_b_Ex),
    .md_busy (md_busy),
    .hi      (hi_out),
    .lo      (lo_out)
  );

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage: ALU ops, mul/div timing, HI/LO moves, reset abort.
module tb_ex_stage;
  import ex_pkg::*;

  logic        clk;
  logic        reset;
  logic        valid_Ex;
  logic [31:0] src_a_Ex, src_b_Ex;
  logic [4:0]  shamt_Ex;
  logic [3:0]  alu_op_Ex, md_op_Ex;
  logic [31:0] aluAns_Ex, hi_out, lo_out;
  logic        md_busy;

  int   checks;
  int   errors;
  logic allow_illegal;

  ex_stage dut (
    .clk       (clk),
    .reset     (reset),
    .valid_Ex  (valid_Ex),
    .src_a_Ex  (src_a_Ex),
    .src_b_Ex  (src_b_Ex),
    .shamt_Ex  (shamt_Ex),
    .alu_op_Ex (alu_op_Ex),
    .md_op_Ex  (md_op_Ex),
    .aluAns_Ex (aluAns_Ex),
    .md_busy   (md_busy),
    .hi_out    (hi_out),
    .lo_out    (lo_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The hazard unit must never issue an MD op while the unit is busy.
  always @(negedge clk) begin
    if (!reset && !allow_illegal && dut.u_md.busy && valid_Ex && (md_op_Ex != MD_NONE)) begin
      errors++;
      $display("FAIL illegal_issue md_op=%0d issued while busy", md_op_Ex);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] md, input logic [3:0] alu,
                       input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
    valid_Ex  = v;
    md_op_Ex  = md;
    alu_op_Ex = alu;
    src_a_Ex  = a;
    src_b_Ex  = b;
    shamt_Ex  = sh;
  endtask

  task automatic idle();
    drive(1'b0, MD_NONE, ALU_ADD, 32'h0, 32'h0, 5'd0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b1, MD_MULT, ALU_ADD, 32'd3, 32'd4, 5'd0);
    #1;
    checks++; if (md_busy !== 1'b1) begin errors++; $display("FAIL rst_busy_start got %b exp 1", md_busy); end
    idle();
    #1;
    checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL rst_busy_idle got %b exp 0", md_busy); end
    cyc();
    cyc();
    reset = 1'b0;
    #1;
    checks++; if (hi_out !== 32'h0) begin errors++; $display("FAIL rst_hi got %h exp 0", hi_out); end
    checks++; if (lo_out !== 32'h0) begin errors++; $display("FAIL rst_lo got %h exp 0", lo_out); end
    checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL rst_busy_after got %b exp 0", md_busy); end
  endtask

  task automatic test_alu();
    logic [3:0]  op;
    logic [31:0] a, b, exp;
    logic [4:0]  sh;
    for (int i = 0; i < 15; i++) begin
      sh = 5'd0;
      case (i)
        0:  begin op = ALU_ADD;  a = 32'h7FFFFFFF; b = 32'h1;        exp = 32'h80000000; end
        1:  begin op = ALU_SUB;  a = 32'd5;        b = 32'd7;        exp = 32'hFFFFFFFE; end
        2:  begin op = ALU_AND;  a = 32'hF0F0F0F0; b = 32'hFF00FF00; exp = 32'hF000F000; end
        3:  begin op = ALU_OR;   a = 32'hF0F0F0F0; b = 32'hFF00FF00; exp = 32'hFFF0FFF0; end
        4:  begin op = ALU_XOR;  a = 32'hF0F0F0F0; b = 32'hFF00FF00; exp = 32'h0FF00FF0; end
        5:  begin op = ALU_NOR;  a = 32'hF0F0F0F0; b = 32'hFF00FF00; exp = 32'h000F000F; end
        6:  begin op = ALU_SLT;  a = 32'hFFFFFFFF; b = 32'h1;        exp = 32'h1;        end
        7:  begin op = ALU_SLTU; a = 32'hFFFFFFFF; b = 32'h1;        exp = 32'h0;        end
        8:  begin op = ALU_SLL;  a = 32'h0;        b = 32'h1;        exp = 32'h80000000; sh = 5'd31; end
        9:  begin op = ALU_SRL;  a = 32'h0;        b = 32'h80000000; exp = 32'h08000000; sh = 5'd4; end
        10: begin op = ALU_SRA;  a = 32'h0;        b = 32'h80000000; exp = 32'hF8000000; sh = 5'd4; end
        11: begin op = ALU_SLLV; a = 32'h4;        b = 32'h3;        exp = 32'h30;       sh = 5'd9; end
        12: begin op = ALU_SRLV; a = 32'h24;       b = 32'h100;      exp = 32'h10;       end
        13: begin op = ALU_SRAV; a = 32'h1;        b = 32'h80000000; exp = 32'hC0000000; end
        default: begin op = ALU_LUI; a = 32'hFFFF; b = 32'hABCD1234; exp = 32'h12340000; end
      endcase
      cyc();
      drive(1'b1, MD_NONE, op, a, b, sh);
      #1;
      checks++;
      if (aluAns_Ex !== exp) begin errors++; $display("FAIL alu_op%0d got %h exp %h", op, aluAns_Ex, exp); end
    end
  endtask

  task automatic test_mt();
    cyc();
    drive(1'b1, MD_MTHI, ALU_ADD, 32'h0000DEAD, 32'h0, 5'd0);
    #1;
    checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL mthi_busy got %b exp 0", md_busy); end
    cyc();
    drive(1'b1, MD_MFHI, ALU_ADD, 32'h0, 32'h0, 5'd0);
    #1;
    checks++; if (aluAns_Ex !== 32'h0000DEAD) begin errors++; $display("FAIL mfhi_after_mthi got %h exp 0000dead", aluAns_Ex); end
    checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL mfhi_busy got %b exp 0", md_busy); end
    cyc();
    drive(1'b1, MD_MTLO, ALU_ADD, 32'h0000BEEF, 32'h0, 5'd0);
    cyc();
    idle();
    #1;
    checks++; if (lo_out !== 32'h0000BEEF) begin errors++; $display("FAIL mtlo got %h exp 0000beef", lo_out); end
    checks++; if (hi_out !== 32'h0000DEAD) begin errors++; $display("FAIL mtlo_hi got %h exp 0000dead", hi_out); end
  endtask

  task automatic test_bubble();
    cyc();
    drive(1'b0, MD_MULT, ALU_ADD, 32'd5, 32'd6, 5'd0);
    #1;
    checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL bubble_busy got %b exp 0", md_busy); end
    drive(1'b0, MD_MTHI, ALU_ADD, 32'h1111, 32'h0, 5'd0);
    for (int i = 0; i < 7; i++) begin
      cyc();
      idle();
      #1;
      checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL bubble_busy_%0d got %b exp 0", i, md_busy); end
    end
    checks++; if (hi_out !== 32'h0000DEAD) begin errors++; $display("FAIL bubble_hi got %h exp 0000dead", hi_out); end
    checks++; if (lo_out !== 32'h0000BEEF) begin errors++; $display("FAIL bubble_lo got %h exp 0000beef", lo_out); end
  endtask

  task automatic test_mult();
    cyc();
    drive(1'b1, MD_MULT, ALU_ADD, 32'hFFFFFFFD, 32'd7, 5'd0);
    #1;
    checks++; if (md_busy !== 1'b1) begin errors++; $display("FAIL mult_busy_0 got %b exp 1", md_busy); end
    for (int i = 1; i <= 5; i++) begin
      cyc();
      allow_illegal = (i == 3);
      if (i == 3) drive(1'b1, MD_MFLO, ALU_ADD, 32'h0, 32'h0, 5'd0);
      else idle();
      #1;
      checks++; if (md_busy !== 1'b1) begin errors++; $display("FAIL mult_busy_%0d got %b exp 1", i, md_busy); end
      if (i == 3) begin
        checks++; if (aluAns_Ex !== 32'h0000BEEF) begin errors++; $display("FAIL mult_mflo_early got %h exp 0000beef", aluAns_Ex); end
      end
    end
    cyc();
    allow_illegal = 1'b0;
    drive(1'b1, MD_MFLO, ALU_ADD, 32'h0, 32'h0, 5'd0);
    #1;
    checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL mult_busy_6 got %b exp 0", md_busy); end
    checks++; if (aluAns_Ex !== 32'hFFFFFFEB) begin errors++; $display("FAIL mult_mflo got %h exp ffffffeb", aluAns_Ex); end
    drive(1'b1, MD_MFHI, ALU_ADD, 32'h0, 32'h0, 5'd0);
    #1;
    checks++; if (aluAns_Ex !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_mfhi got %h exp ffffffff", aluAns_Ex); end
  endtask

  task automatic test_div();
    cyc();
    drive(1'b1, MD_DIV, ALU_ADD, 32'hFFFFFFF9, 32'd2, 5'd0);
    #1;
    checks++; if (md_busy !== 1'b1) begin errors++; $display("FAIL div_busy_0 got %b exp 1", md_busy); end
    for (int i = 1; i <= 10; i++) begin
      cyc();
      idle();
      #1;
      checks++; if (md_busy !== 1'b1) begin errors++; $display("FAIL div_busy_%0d got %b exp 1", i, md_busy); end
    end
    cyc();
    drive(1'b1, MD_MFLO, ALU_ADD, 32'h0, 32'h0, 5'd0);
    #1;
    checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL div_busy_11 got %b exp 0", md_busy); end
    checks++; if (aluAns_Ex !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_lo got %h exp fffffffd", aluAns_Ex); end
    checks++; if (hi_out !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_hi got %h exp ffffffff", hi_out); end
  endtask

  task automatic test_divu_zero();
    cyc();
    drive(1'b1, MD_DIVU, ALU_ADD, 32'd7, 32'd0, 5'd0);
    for (int i = 1; i <= 10; i++) begin
      cyc();
      idle();
      #1;
      checks++; if (md_busy !== 1'b1) begin errors++; $display("FAIL divz_busy_%0d got %b exp 1", i, md_busy); end
    end
    cyc();
    #1;
    checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL divz_busy_11 got %b exp 0", md_busy); end
    checks++; if (hi_out !== 32'hFFFFFFFF) begin errors++; $display("FAIL divz_hi got %h exp ffffffff", hi_out); end
    checks++; if (lo_out !== 32'hFFFFFFFD) begin errors++; $display("FAIL divz_lo got %h exp fffffffd", lo_out); end
  endtask

  task automatic test_div_ovf();
    cyc();
    drive(1'b1, MD_DIV, ALU_ADD, 32'h80000000, 32'hFFFFFFFF, 5'd0);
    for (int i = 1; i <= 10; i++) begin
      cyc();
      idle();
    end
    cyc();
    #1;
    checks++; if (lo_out !== 32'h80000000) begin errors++; $display("FAIL divovf_lo got %h exp 80000000", lo_out); end
    checks++; if (hi_out !== 32'h0) begin errors++; $display("FAIL divovf_hi got %h exp 0", hi_out); end
  endtask

  task automatic test_reset_abort();
    cyc();
    drive(1'b1, MD_MULTU, ALU_ADD, 32'hFFFFFFFF, 32'd2, 5'd0);
    cyc();
    idle();
    cyc();
    reset = 1'b1;
    #1;
    checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL abort_busy_in_reset got %b exp 0", md_busy); end
    cyc();
    reset = 1'b0;
    #1;
    checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", md_busy); end
    checks++; if (hi_out !== 32'h0) begin errors++; $display("FAIL abort_hi got %h exp 0", hi_out); end
    checks++; if (lo_out !== 32'h0) begin errors++; $display("FAIL abort_lo got %h exp 0", lo_out); end
    for (int i = 0; i < 5; i++) cyc();
    checks++; if (lo_out !== 32'h0) begin errors++; $display("FAIL abort_no_commit_lo got %h exp 0", lo_out); end
    checks++; if (hi_out !== 32'h0) begin errors++; $display("FAIL abort_no_commit_hi got %h exp 0", hi_out); end
    drive(1'b1, MD_DIVU, ALU_ADD, 32'd100, 32'd7, 5'd0);
    #1;
    checks++; if (md_busy !== 1'b1) begin errors++; $display("FAIL post_rst_start got %b exp 1", md_busy); end
    for (int i = 1; i <= 10; i++) begin
      cyc();
      idle();
    end
    cyc();
    #1;
    checks++; if (lo_out !== 32'd14) begin errors++; $display("FAIL post_rst_lo got %h exp 0000000e", lo_out); end
    checks++; if (hi_out !== 32'd2) begin errors++; $display("FAIL post_rst_hi got %h exp 00000002", hi_out); end
  endtask

  task automatic test_back_to_back();
    cyc();
    drive(1'b1, MD_MULT, ALU_ADD, 32'h00010000, 32'h00010000, 5'd0);
    for (int i = 1; i <= 5; i++) begin
      cyc();
      allow_illegal = (i == 5);
      if (i == 5) drive(1'b1, MD_DIVU, ALU_ADD, 32'd9, 32'd2, 5'd0);
      else idle();
      #1;
      checks++; if (md_busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_%0d got %b exp 1", i, md_busy); end
    end
    cyc();
    allow_illegal = 1'b0;
    drive(1'b1, MD_DIVU, ALU_ADD, 32'd100, 32'd3, 5'd0);
    #1;
    checks++; if (hi_out !== 32'h1) begin errors++; $display("FAIL b2b_mult_hi got %h exp 00000001", hi_out); end
    checks++; if (lo_out !== 32'h0) begin errors++; $display("FAIL b2b_mult_lo got %h exp 0", lo_out); end
    checks++; if (md_busy !== 1'b1) begin errors++; $display("FAIL b2b_div_start got %b exp 1", md_busy); end
    for (int i = 1; i <= 10; i++) begin
      cyc();
      idle();
      #1;
      checks++; if (md_busy !== 1'b1) begin errors++; $display("FAIL b2b_div_busy_%0d got %b exp 1", i, md_busy); end
    end
    cyc();
    drive(1'b1, MD_MFLO, ALU_ADD, 32'h0, 32'h0, 5'd0);
    #1;
    checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL b2b_div_done got %b exp 0", md_busy); end
    checks++; if (aluAns_Ex !== 32'h21) begin errors++; $display("FAIL b2b_div_lo got %h exp 00000021", aluAns_Ex); end
    checks++; if (hi_out !== 32'h1) begin errors++; $display("FAIL b2b_div_hi got %h exp 00000001", hi_out); end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    allow_illegal = 1'b0;
    reset         = 1'b1;
    idle();
    test_reset();
    test_alu();
    test_mt();
    test_bubble();
    test_mult();
    test_div();
    test_divu_zero();
    test_div_ovf();
    test_reset_abort();
    test_back_to_back();
    cyc();
    idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
